// File: rtl/eth_frame_matcher.sv
// eth_frame_matcher: compares each RX frame against masked byte patterns and emits one timestamped record per matching frame.
module eth_frame_matcher #(
    parameter int NUM_PATTERNS = 4,
    parameter int PATTERN_LEN  = 64,
    parameter int PIDX_W       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    parameter int BIDX_W       = $clog2(PATTERN_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [PIDX_W-1:0]       cfg_pattern,
    input  logic [BIDX_W-1:0]       cfg_addr,
    input  logic [7:0]              cfg_data,
    input  logic                    cfg_mask,
    input  logic [NUM_PATTERNS-1:0] cfg_enable,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    input  logic [63:0]             current_time,
    input  logic                    time_running,
    output logic                    match_valid,
    input  logic                    match_ready,
    output logic [NUM_PATTERNS-1:0] match_mask,
    output logic [63:0]             match_time,
    output logic [15:0]             match_len,
    output logic [15:0]             overflow_count,
    output logic [15:0]             bad_count
);
    typedef enum logic [1:0] {SYNC, IDLE, FRAME, DISCARD} state_t;
    state_t state_q, state_d;
    logic [PATTERN_LEN-1:0][7:0] data_q [NUM_PATTERNS];
    logic [PATTERN_LEN-1:0][7:0] data_d [NUM_PATTERNS];
    logic [PATTERN_LEN-1:0]      mask_q [NUM_PATTERNS];
    logic [PATTERN_LEN-1:0]      mask_d [NUM_PATTERNS];
    logic [15:0]                 cnt_q, cnt_d;
    logic [NUM_PATTERNS-1:0]     alive_q, alive_d, alive_nx, hit;
    logic [63:0]                 time_q, time_d;
    logic                        mvalid_q, mvalid_d;
    logic [NUM_PATTERNS-1:0]     mmask_q, mmask_d;
    logic [63:0]                 mtime_q, mtime_d;
    logic [15:0]                 mlen_q, mlen_d;
    logic [15:0]                 ovf_q, ovf_d;
    logic [15:0]                 bad_q, bad_d;
    logic                        fresh, in_pat, eval, rec;
    logic [15:0]                 idx;
    logic [BIDX_W-1:0]           bidx;
    logic [16:0]                 shamt;
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (cfg_we && int'(cfg_pattern) < NUM_PATTERNS && int'(cfg_addr) < PATTERN_LEN) begin
            data_d[cfg_pattern][cfg_addr] = cfg_data;
            mask_d[cfg_pattern][cfg_addr] = cfg_mask;
        end
    end
    // In IDLE the current beat is byte 0 of a new frame, so every pattern starts alive.
    always_comb begin
        fresh    = state_q == IDLE;
        idx      = fresh ? 16'd0 : cnt_q;
        in_pat   = int'(idx) < PATTERN_LEN;
        bidx     = idx[BIDX_W-1:0];
        shamt    = {1'b0, idx} + 17'd1;
        alive_nx = '0;
        hit      = '0;
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            alive_nx[p] = (fresh | alive_q[p]) &
                          ~(in_pat & mask_q[p][bidx] & (s_axis_tdata != data_q[p][bidx]));
            hit[p]      = alive_nx[p] & cfg_enable[p] & ~|(mask_q[p] >> shamt);
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alive_d = alive_q;
        time_d  = time_q;
        eval    = 1'b0;
        case (state_q)
            SYNC: state_d = (s_axis_tvalid && s_axis_tlast) ? IDLE : SYNC;
            IDLE: begin
                if (s_axis_tvalid && time_running) begin
                    time_d  = current_time;
                    cnt_d   = 16'd1;
                    alive_d = alive_nx;
                    eval    = s_axis_tlast;
                    state_d = s_axis_tlast ? IDLE : FRAME;
                end else if (s_axis_tvalid) begin
                    state_d = s_axis_tlast ? IDLE : DISCARD;
                end
            end
            FRAME: begin
                if (s_axis_tvalid) begin
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
                    alive_d = alive_nx;
                    eval    = s_axis_tlast;
                    state_d = s_axis_tlast ? IDLE : FRAME;
                end
            end
            default: state_d = (s_axis_tvalid && s_axis_tlast) ? IDLE : DISCARD;
        endcase
    end
    // A record arriving during an accepting handshake replaces the old one; otherwise it is dropped while busy.
    always_comb begin
        rec      = eval & ~s_axis_tuser & (|hit);
        mvalid_d = mvalid_q;
        mmask_d  = mmask_q;
        mtime_d  = mtime_q;
        mlen_d   = mlen_q;
        ovf_d    = ovf_q;
        bad_d    = (eval && s_axis_tuser && !(&bad_q)) ? bad_q + 16'd1 : bad_q;
        if (rec && (!mvalid_q || match_ready)) begin
            mvalid_d = 1'b1;
            mmask_d  = hit;
            mtime_d  = fresh ? current_time : time_q;
            mlen_d   = (&idx) ? idx : idx + 16'd1;
        end else if (rec) begin
            ovf_d = (&ovf_q) ? ovf_q : ovf_q + 16'd1;
        end else if (mvalid_q && match_ready) begin
            mvalid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SYNC;
            cnt_q    <= '0;
            alive_q  <= '0;
            time_q   <= '0;
            mvalid_q <= 1'b0;
            mmask_q  <= '0;
            mtime_q  <= '0;
            mlen_q   <= '0;
            ovf_q    <= '0;
            bad_q    <= '0;
            for (int p = 0; p < NUM_PATTERNS; p++) begin
                data_q[p] <= '0;
                mask_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alive_q  <= alive_d;
            time_q   <= time_d;
            mvalid_q <= mvalid_d;
            mmask_q  <= mmask_d;
            mtime_q  <= mtime_d;
            mlen_q   <= mlen_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
        end
    end
    assign match_valid    = mvalid_q;
    assign match_mask     = mmask_q;
    assign match_time     = mtime_q;
    assign match_len      = mlen_q;
    assign overflow_count = ovf_q;
    assign bad_count      = bad_q;
endmodule

// File: tb/tb_eth_frame_matcher.sv
// tb_eth_frame_matcher: directed frame vectors plus hand-written sequences for back-to-back frames, saturation and mid-frame reset.
module tb_eth_frame_matcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_pattern = '0;
    logic [5:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_mask = 1'b0;
    logic [3:0]  cfg_enable = '0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] current_time = '0;
    logic        time_running = 1'b1;
    logic        match_valid;
    logic        match_ready = 1'b0;
    logic [3:0]  match_mask;
    logic [63:0] match_time;
    logic [15:0] match_len;
    logic [15:0] overflow_count;
    logic [15:0] bad_count;
    int checks = 0;
    int errors = 0;

    eth_frame_matcher dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_enable(cfg_enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .current_time(current_time), .time_running(time_running),
        .match_valid(match_valid), .match_ready(match_ready), .match_mask(match_mask),
        .match_time(match_time), .match_len(match_len), .overflow_count(overflow_count),
        .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] et;
        logic        tu;
        logic        tr;
        logic [3:0]  en;
        logic [63:0] t0;
        logic        ev;
        logic [3:0]  em;
        logic [63:0] etm;
        logic [15:0] el;
        logic [15:0] eovf;
        logic [15:0] ebad;
        logic        clr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int k, input logic [15:0] et);
        return (k == 12) ? et[15:8] : (k == 13) ? et[7:0] : (k == 14) ? 8'h45 : 8'(k);
    endfunction

    task automatic wr(input logic [1:0] p, input logic [5:0] a, input logic [7:0] d, input logic m);
        cfg_we = 1'b1; cfg_pattern = p; cfg_addr = a; cfg_data = d; cfg_mask = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_all();
        wr(2'd0, 6'd12, 8'h08, 1'b1);
        wr(2'd0, 6'd13, 8'h06, 1'b1);
        wr(2'd1, 6'd12, 8'h86, 1'b1);
        wr(2'd1, 6'd13, 8'hDD, 1'b1);
        wr(2'd2, 6'd0,  8'h00, 1'b1);
        wr(2'd2, 6'd14, 8'h45, 1'b1);
        wr(2'd2, 6'd1,  8'hFF, 1'b0);
        wr(2'd3, 6'd63, 8'h3F, 1'b1);
    endtask

    task automatic send_range(input int from, input int to, input int len, input logic [15:0] et,
                              input logic tu, input logic [63:0] t0, input logic rdy_last);
        for (int k = from; k < to; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fb(k, et);
            s_axis_tlast  = (k == len - 1);
            s_axis_tuser  = (k == len - 1) & tu;
            match_ready   = (k == len - 1) & rdy_last;
            current_time  = t0 + 64'(k);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; match_ready = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [15:0] et, input logic tu,
                              input logic [63:0] t0, input logic rdy_last);
        send_range(0, len, len, et, tu, t0, rdy_last);
    endtask

    task automatic check_rec(input string nm, input logic [3:0] m, input logic [63:0] t, input logic [15:0] l);
        chk({nm, " valid"}, 64'(match_valid), 64'd1);
        chk({nm, " mask"}, 64'(match_mask), 64'(m));
        chk({nm, " time"}, match_time, t);
        chk({nm, " len"}, 64'(match_len), 64'(l));
    endtask

    task automatic clear(input string nm);
        match_ready = 1'b1;
        @(posedge clk); #1;
        match_ready = 1'b0;
        chk({nm, " cleared"}, 64'(match_valid), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{64, 16'h0806, 1'b0, 1'b1, 4'b0001, 64'd100,  1'b1, 4'b0001, 64'd100, 16'd64, 16'd0, 16'd0, 1'b1};
        tbl[1]  = '{10, 16'h0806, 1'b0, 1'b1, 4'b0001, 64'd200,  1'b0, 4'b0000, 64'd0,   16'd0,  16'd0, 16'd0, 1'b0};
        tbl[2]  = '{20, 16'h0806, 1'b0, 1'b1, 4'b0101, 64'd300,  1'b1, 4'b0101, 64'd300, 16'd20, 16'd0, 16'd0, 1'b0};
        tbl[3]  = '{20, 16'h0806, 1'b0, 1'b1, 4'b0101, 64'd400,  1'b1, 4'b0101, 64'd300, 16'd20, 16'd1, 16'd0, 1'b1};
        tbl[4]  = '{64, 16'h86DD, 1'b0, 1'b1, 4'b1111, 64'd500,  1'b1, 4'b1110, 64'd500, 16'd64, 16'd1, 16'd0, 1'b1};
        tbl[5]  = '{63, 16'h86DD, 1'b0, 1'b1, 4'b1111, 64'd600,  1'b1, 4'b0110, 64'd600, 16'd63, 16'd1, 16'd0, 1'b1};
        tbl[6]  = '{15, 16'h0806, 1'b0, 1'b1, 4'b0100, 64'd700,  1'b1, 4'b0100, 64'd700, 16'd15, 16'd1, 16'd0, 1'b1};
        tbl[7]  = '{14, 16'h0806, 1'b0, 1'b1, 4'b0100, 64'd800,  1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd0, 1'b0};
        tbl[8]  = '{20, 16'h0806, 1'b1, 1'b1, 4'b0001, 64'd900,  1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd1, 1'b0};
        tbl[9]  = '{20, 16'h0806, 1'b0, 1'b0, 4'b0001, 64'd1000, 1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd1, 1'b0};
        tbl[10] = '{20, 16'h0806, 1'b1, 1'b0, 4'b0001, 64'd1100, 1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd1, 1'b0};
        tbl[11] = '{64, 16'h0806, 1'b0, 1'b1, 4'b0000, 64'd1200, 1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd1, 1'b0};
        tbl[12] = '{1,  16'h0806, 1'b0, 1'b1, 4'b1111, 64'd1300, 1'b0, 4'b0000, 64'd0,   16'd0,  16'd1, 16'd1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 64'(match_valid), 64'd0);
        chk("reset mask", 64'(match_mask), 64'd0);
        chk("reset time", match_time, 64'd0);
        chk("reset len", 64'(match_len), 64'd0);
        chk("reset ovf", 64'(overflow_count), 64'd0);
        chk("reset bad", 64'(bad_count), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Leave SYNC, then check that cleared masks make an enabled pattern match anything.
        send_frame(1, 16'h0000, 1'b0, 64'd10, 1'b0);
        chk("sync no record", 64'(match_valid), 64'd0);
        cfg_enable = 4'b0001;
        send_frame(3, 16'h0000, 1'b0, 64'd50, 1'b0);
        check_rec("empty mask", 4'b0001, 64'd50, 16'd3);
        clear("empty mask");

        cfg_all();
        for (int i = 0; i < 13; i++) begin
            cfg_enable   = tbl[i].en;
            time_running = tbl[i].tr;
            send_frame(tbl[i].len, tbl[i].et, tbl[i].tu, tbl[i].t0, 1'b0);
            chk($sformatf("v%0d valid", i), 64'(match_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) check_rec($sformatf("v%0d", i), tbl[i].em, tbl[i].etm, tbl[i].el);
            chk($sformatf("v%0d ovf", i), 64'(overflow_count), 64'(tbl[i].eovf));
            chk($sformatf("v%0d bad", i), 64'(bad_count), 64'(tbl[i].ebad));
            if (tbl[i].clr) clear($sformatf("v%0d", i));
        end
        time_running = 1'b1;

        // Back-to-back frames; second record loads during the handshake that accepts the first.
        cfg_enable = 4'b0001;
        send_frame(20, 16'h0806, 1'b0, 64'd2000, 1'b0);
        check_rec("b2b first", 4'b0001, 64'd2000, 16'd20);
        send_frame(30, 16'h0806, 1'b0, 64'd3000, 1'b1);
        check_rec("b2b second", 4'b0001, 64'd3000, 16'd30);
        chk("b2b ovf", 64'(overflow_count), 64'd1);
        clear("b2b");

        send_frame(70000, 16'h0806, 1'b0, 64'd10000, 1'b0);
        check_rec("long frame", 4'b0001, 64'd10000, 16'hFFFF);
        clear("long frame");

        // Reset taken mid-frame; the resumed bytes must not produce a record.
        send_range(0, 10, 64, 16'h0806, 1'b0, 64'd20000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst valid", 64'(match_valid), 64'd0);
        chk("midrst ovf", 64'(overflow_count), 64'd0);
        chk("midrst bad", 64'(bad_count), 64'd0);
        cfg_all();
        send_frame(64, 16'h0806, 1'b0, 64'd30000, 1'b0);
        chk("midrst resumed", 64'(match_valid), 64'd0);
        send_frame(64, 16'h0806, 1'b0, 64'd40000, 1'b0);
        check_rec("midrst next", 4'b0001, 64'd40000, 16'd64);
        clear("midrst next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_frame_matcher.md
Name: eth_frame_matcher

Overview:
- Parametrised successor of the per-interface frame detector: compares every received frame against NUM_PATTERNS masked byte patterns, each up to PATTERN_LEN bytes.
- Emits one timestamped match record per frame that matches at least one enabled pattern.
- Sits on the RX AXI4-Stream tap from a TEMAC, one instance per interface.
- Config and result ports are driven by the AXI-Lite register front end.

Parameters:
NUM_PATTERNS, 4, number of independent patterns (1..16)
PATTERN_LEN, 64, bytes compared per pattern, starting at frame byte 0 (2..256)
PIDX_W, $clog2(NUM_PATTERNS) (min 1), pattern index width (derived)
BIDX_W, $clog2(PATTERN_LEN), byte index width (derived)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous active-high reset
cfg_we  in  1  pattern byte write strobe
cfg_pattern  in  PIDX_W  pattern index for the write
cfg_addr  in  BIDX_W  byte index for the write
cfg_data  in  8  expected byte value
cfg_mask  in  1  1 = byte is compared, 0 = don't care
cfg_enable  in  NUM_PATTERNS  per-pattern enable, sampled at frame end
s_axis_tdata  in  8  RX byte
s_axis_tuser  in  1  bad-frame flag, valid on the tlast beat
s_axis_tlast  in  1  last byte of frame
s_axis_tvalid  in  1  byte valid (no backpressure)
current_time  in  64  free-running timer
time_running  in  1  capture enable
match_valid  out  1  match record available
match_ready  in  1  consumer accepts record
match_mask  out  NUM_PATTERNS  patterns matched by the frame
match_time  out  64  current_time at the frame's first byte
match_len  out  16  frame length in bytes (saturating)
overflow_count  out  16  records dropped because the output was busy (saturating)
bad_count  out  16  frames ending with tuser=1 (saturating)

Behaviour:
- Reset values:
  - All outputs 0.
  - All pattern bytes 0; all mask bits 0.
  - FSM state SYNC.
- Storage: per pattern, a PATTERN_LEN x 8 data array and a PATTERN_LEN-bit mask vector, in registers.
  - cfg_we writes data[cfg_pattern][cfg_addr] and mask[cfg_pattern][cfg_addr] on the rising edge.
  - A byte compared in the same cycle as a write to that location uses the old value.
  - Writes are permitted mid-frame. Comparisons already made are not revisited.
- FSM states and transitions:
  - SYNC: ignore bytes until a beat with tvalid&tlast, then go to IDLE. This keeps a reset taken mid-frame from producing a partial result.
  - IDLE, on tvalid with time_running=1: latch current_time, set byte counter to 1, process byte 0, go to FRAME.
    - If tlast is also set: evaluate immediately and stay in IDLE.
  - IDLE, on tvalid with time_running=0: go to DISCARD, or stay in IDLE if tlast.
  - FRAME: each tvalid beat processes byte idx = counter, then the counter increments, saturating at 16'hFFFF. On tlast: evaluate, go to IDLE.
  - DISCARD: on tvalid&tlast go to IDLE. No record is produced and no counter changes.
- Per-pattern alive bit:
  - Set to 1 at frame start.
  - While idx < PATTERN_LEN, cleared when mask[p][idx]=1 and the byte differs from data[p][idx].
  - Bytes at idx >= PATTERN_LEN are not compared.
- Evaluation on the tlast beat at index i, including that byte's comparison:
  - hit[p] = alive[p] & cfg_enable[p] & ~(|(mask[p] >> (i+1))).
  - A frame shorter than a pattern's highest masked byte therefore never matches it.
  - i >= PATTERN_LEN-1 imposes no length condition.
- Frame with tuser=1: bad_count increments (saturating). No record is produced.
- Good frame with hit != 0: a record {hit, latched time, length = i+1 saturated} is produced one cycle after the tlast beat.
- Good frame with hit == 0: no record.
- Output handshake:
  - match_valid stays high, with its fields stable, until match_valid&match_ready.
  - New record while match_valid=1 and match_ready=0: the new record is dropped, the held record is kept, overflow_count increments (saturating).
  - New record in the same cycle as an accepting handshake: the new record is loaded and match_valid stays 1.
- The stream side never stalls. Back-to-back frames (tlast followed immediately by the next byte) are fully supported.

Test Plan:
- Reset, then a 64-byte frame arrives (first byte at current_time=100), pattern 0 masks bytes 12..13 = 0x08,0x06, frame carries 0x0806, cfg_enable=0001 -> one cycle after tlast: match_valid=1, match_mask=0001, match_time=100, match_len=64.
- Same pattern, but a 10-byte frame with tlast at i=9 -> no record; masked bytes lie beyond the frame end.
- Patterns 0 and 2 both match, match_ready held at 0, two such frames -> first record held with mask=0101, overflow_count=1; raising match_ready clears match_valid.
- Matching frame ending with tuser=1 -> no record, bad_count=1; matching frame received while time_running=0 -> no record and no counter change.
- rst asserted mid-frame, frame resumes -> remainder discarded (SYNC); next full matching frame -> exactly one record.
- 70000-byte frame, PATTERN_LEN=64, pattern matches -> match_len=16'hFFFF, match_mask correct.
